// File: rtl/serial_subtractor.sv
// Multi-cycle N-bit subtractor: d = a - b - bin, STEP bits per clock LSB-first,
// with a start/busy/done handshake and registered borrow-out and signed overflow.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 2 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_params
      $error("serial_subtractor: WIDTH must be >= 2 and a multiple of STEP");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_nxt;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic [STEP:0]    chunk;
  logic             last;
  logic             accept;
  logic             ovf_nxt;

  always_comb begin
    chunk  = {1'b0, a_sr[STEP-1:0]} - {1'b0, b_sr[STEP-1:0]} - (STEP+1)'(borrow);
    last   = (cnt == CW'(N - 1));
    accept = start && (state != RUN);
    // Operands of opposite sign whose result sign differs from the minuend
    // overflowed; equivalent to borrow-into-MSB XOR borrow-out-of-MSB.
    ovf_nxt = (a_sr[STEP-1] ^ b_sr[STEP-1]) & (chunk[STEP-1] ^ a_sr[STEP-1]);
  end

  generate
    if (STEP == WIDTH) begin : g_single_chunk
      assign res_nxt = chunk[STEP-1:0];
    end else begin : g_multi_chunk
      assign res_nxt = {chunk[STEP-1:0], res_sr[WIDTH-1:STEP]};
    end
  endgenerate

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every datapath register is reset so an aborted operation leaves no
  // stale operands, partial result or borrow behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      borrow <= bin;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> STEP;
      b_sr   <= b_sr >> STEP;
      res_sr <= res_nxt;
      borrow <= chunk[STEP];
      cnt    <= cnt + CW'(1);
      if (last) begin
        d    <= res_nxt;
        bout <= chunk[STEP];
        ovf  <= ovf_nxt;
      end
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vector table over several
// WIDTH/STEP instances, hand-written abort/ignore sequences, and a back-to-back random run.
module tb_serial_subtractor;

  localparam int NI = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        mon_en = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  logic        busy_v [NI];
  logic        done_v [NI];
  logic [15:0] d_v    [NI];
  logic        bout_v [NI];
  logic        ovf_v  [NI];
  int          ops_v  [NI];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {ovf, bout, d[15:0]} computed with plain integer arithmetic.
  function automatic logic [17:0] model(input int w, input logic [15:0] av16,
                                        input logic [15:0] bv16, input logic bi);
    int mask, av, bv, dd, sa, sb, r, half;
    logic bo, ov;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    av   = int'(av16) & mask;
    bv   = int'(bv16) & mask;
    bo   = (av < bv + int'(bi));
    dd   = (av - bv - int'(bi)) & mask;
    sa   = (av >= half) ? av - (1 << w) : av;
    sb   = (bv >= half) ? bv - (1 << w) : bv;
    r    = sa - sb - int'(bi);
    ov   = (r < -half) || (r > half - 1);
    return {ov, bo, 16'(dd)};
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int W  = (gi < 4) ? 8 : 16;
    localparam int S  = (gi < 4) ? (1 << gi) : (1 << (gi - 4));
    localparam int NS = W / S;
    logic [W-1:0] d_r;
    logic [15:0]  pa, pb;
    logic         pbin;
    logic         pval;
    int           last_done;

    serial_subtractor #(.WIDTH(W), .STEP(S)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a[W-1:0]),
      .b     (b[W-1:0]),
      .bin   (bin),
      .busy  (busy_v[gi]),
      .done  (done_v[gi]),
      .d     (d_r),
      .bout  (bout_v[gi]),
      .ovf   (ovf_v[gi])
    );
    assign d_v[gi] = 16'(d_r);

    always @(negedge clk) begin
      if (!rst_n) begin
        pval      <= 1'b0;
        last_done <= -1;
        ops_v[gi] <= 0;
      end else if (mon_en) begin
        if (busy_v[gi] && done_v[gi]) check("busy_and_done", 1, 0);
        if (done_v[gi]) begin
          if (pval) begin
            check("rand_result", {ovf_v[gi], bout_v[gi], d_v[gi]}, model(W, pa, pb, pbin));
            ops_v[gi] <= ops_v[gi] + 1;
          end
          if (last_done >= 0) check("rand_spacing", cyc - last_done, NS + 1);
          last_done <= cyc;
        end
        if (start && !busy_v[gi]) begin
          pa   <= a;
          pb   <= b;
          pbin <= bin;
          pval <= 1'b1;
        end
      end
    end
  end

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bout;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  task automatic run_op(input int idx, input logic [15:0] av, input logic [15:0] bv,
                        input logic bi, output int lat, output int busy_cnt);
    @(posedge clk); #1;
    a = av; b = bv; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0; bin = 1'b0;
    lat = -1;
    busy_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy_v[idx]) busy_cnt++;
      if (done_v[idx]) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  initial begin
    int lat, bc, ndone, total;
    // idx: 0..3 = W8 S1/2/4/8, 4..8 = W16 S1/2/4/8/16
    vecs[0] = '{0, 16'h05,   16'h03,   1'b1, 16'h01,   1'b0, 1'b0, 8};
    vecs[1] = '{0, 16'h00,   16'h01,   1'b0, 16'hFF,   1'b1, 1'b0, 8};
    vecs[2] = '{0, 16'h80,   16'h01,   1'b0, 16'h7F,   1'b0, 1'b1, 8};
    vecs[3] = '{2, 16'h7F,   16'hFF,   1'b0, 16'h80,   1'b1, 1'b1, 2};
    vecs[4] = '{3, 16'h7F,   16'hFF,   1'b0, 16'h80,   1'b1, 1'b1, 1};
    vecs[5] = '{8, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1};
    vecs[6] = '{4, 16'h1234, 16'h1235, 1'b0, 16'hFFFF, 1'b1, 1'b0, 16};
    vecs[7] = '{1, 16'hFF,   16'hFF,   1'b1, 16'hFF,   1'b1, 1'b0, 4};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #1;
    check("reset_outputs", {busy_v[0], done_v[0], d_v[0], bout_v[0], ovf_v[0]}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].bin, lat, bc);
      check("latency", lat, vecs[i].lat);
      check("busy_cycles", bc, vecs[i].lat);
      check("d", d_v[vecs[i].idx], vecs[i].d);
      check("bout", bout_v[vecs[i].idx], vecs[i].bout);
      check("ovf", ovf_v[vecs[i].idx], vecs[i].ovf);
      @(negedge clk);
      check("done_one_cycle", done_v[vecs[i].idx], 0);
      repeat (20) @(posedge clk);
    end

    // Start re-pulsed while busy must be ignored.
    @(posedge clk); #1;
    a = 16'h20; b = 16'h05; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 a = 16'hAA; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    check("ignored_start_done_count", ndone, 1);
    check("ignored_start_d", d_v[0], 16'h1B);
    check("ignored_start_bout", bout_v[0], 0);

    // Reset in the middle of an operation aborts it.
    @(posedge clk); #1;
    a = 16'h33; b = 16'h11; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {busy_v[0], done_v[0], d_v[0], bout_v[0], ovf_v[0]}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    check("abort_no_done", ndone, 0);
    run_op(0, 16'h10, 16'h10, 1'b0, lat, bc);
    check("after_abort_latency", lat, 8);
    check("after_abort_result", {ovf_v[0], bout_v[0], d_v[0]}, 0);
    repeat (20) @(posedge clk);

    // Back-to-back random operations with start held high.
    @(posedge clk); #1;
    mon_en = 1'b1;
    start  = 1'b1;
    repeat (1000) begin
      a = 16'($urandom);
      b = 16'($urandom);
      bin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (25) @(posedge clk);
    #1 mon_en = 1'b0;
    total = 0;
    for (int i = 0; i < NI; i++) total += ops_v[i];
    check("rand_ops_at_least_1000", total >= 1000, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
